fpu_issue_sched: RTL and testbench
==================================

Name: fpu_issue_sched

Overview:
- Single-outstanding-operation sequencer between the decode stage and the FPU execution units.
- Accepts a decoded fpu_op (the fpu_cntrl encoding) with a valid/ready handshake, then issues a one-cycle start pulse to the FPU datapath.
- Tracks completion using a fixed latency per op class, or the unit's done strobe for div/sqrt.
- Returns the 64-bit result with destination tags over a valid/ready response channel, and stalls decode while busy.

Parameters:
- ADD_LAT, 3: cycles from start to result for add/sub (d and s); range 1..15.
- MUL_LAT, 4: cycles from start to result for mul (d and s); range 1..15.
- MISC_LAT, 1: cycles from start to result for fcvt/fmv (00101..01000); range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  decode presents an op.
- req_ready  out  1  scheduler can accept.
- req_op  in  5  fpu_op code.
- req_rd_idx  in  5  destination register index.
- req_fpu_rd  in  1  destination is an FP register.
- flush  in  1  abandon any in-flight op.
- start  out  1  one-cycle issue pulse to the FPU.
- start_op  out  5  op code qualified by start.
- unit_done  in  1  completion strobe from div/sqrt.
- unit_result  in  64  FPU result bus.
- resp_valid  out  1  result available.
- resp_ready  in  1  writeback accepts the result.
- resp_data  out  64  captured result.
- resp_rd_idx  out  5  destination index.
- resp_fpu_rd  out  1  destination-is-FP tag.
- illegal  out  1  one-cycle pulse for an unsupported op.
- busy  out  1  state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs are 0, the state is IDLE, and the counter is 0.
- States: IDLE, ISSUE, COUNT, WAIT, RESP.
- Ready rule: req_ready = (state==IDLE) && !flush. An op is accepted on req_valid && req_ready.
- Latching on accept: req_op, req_rd_idx and req_fpu_rd are latched. The op is classified as follows:
  - add class: 00000, 00001, 01001, 01010.
  - mul class: 00010, 01011.
  - var class: 00011, 00100, 01100, 01101.
  - misc class: 00101..01000.
  - illegal: 01110..11111.
- Illegal op accepted in cycle A: illegal=1 in cycle A+1 only. start is never asserted, no response is produced, and the state stays IDLE, so a new op can be accepted in cycle A+1.
- ISSUE: entered in cycle A+1 for a legal op. start=1 and start_op=latched op for exactly this cycle. The next state is COUNT (fixed class, with the counter loaded with LAT) or WAIT (var class).
- COUNT: the counter decrements each cycle. In the cycle where the counter equals 1, unit_result is captured into resp_data and the state moves to RESP.
  - Capture happens in cycle A+1+LAT, so resp_valid first rises in cycle A+2+LAT.
  - unit_done is ignored in this state.
- WAIT: unit_done=1 captures unit_result and moves to RESP. unit_done is honoured in any WAIT cycle, including the first one (cycle A+2). There is no timeout; the scheduler waits indefinitely.
- RESP: resp_valid=1. resp_data, resp_rd_idx and resp_fpu_rd stay stable until resp_valid && resp_ready; in that cycle the state moves to IDLE.
  - resp_valid falls the following cycle.
  - req_ready is low throughout RESP, so there is no same-cycle accept.
- unit_done outside WAIT: ignored, including a stray done after a flush.
- flush in any state: the next state is IDLE and resp_valid drops the next cycle.
  - No start is asserted in the cycle after flush.
  - A flush coinciding with req_valid is not accepted.
  - A flush coinciding with a RESP handshake means the result counts as delivered and has no further effect.
- Reset mid-operation: identical to flush, and in addition all outputs are cleared.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Add timing: reset, then accept req_op=00000, rd=7, fpu_rd=1 in cycle 0, with unit_result=64'h4008000000000000 in cycle 4. Required: start=1 only in cycle 1, resp_valid rises in cycle 5 with resp_data=64'h4008000000000000, resp_rd_idx=7, resp_fpu_rd=1.
- Response back-pressure: mul op 01011 with resp_ready held low for 6 cycles. Required: resp_valid rises in cycle 6 and stays asserted with stable data until resp_ready=1; req_ready=0 throughout; IDLE and req_ready=1 the cycle after the handshake.
- Variable latency: div op 00011 with unit_done pulsed in cycle 20, result=64'h3FE0000000000000. Required: capture in cycle 20, resp_valid rises in cycle 21; a unit_done in cycle 4 of a concurrent misc test is ignored.
- Illegal op: req_op=11111 accepted in cycle 0. Required: illegal=1 in cycle 1 only, start never asserted, req_ready=1 in cycle 1; a 00101 op accepted in cycle 1 issues start in cycle 2.
- Flush: fsqrt 01101 issued, flush asserted in cycle 5 while in WAIT, then unit_done in cycle 8. Required: IDLE in cycle 6, busy=0, no resp_valid at any point.
- Reset in the middle of COUNT: assert rst in cycle 2 of a MUL_LAT op. Required: all outputs 0 and IDLE the next cycle; no response afterwards.

Source files
------------

// File: rtl/fpu_issue_sched.sv
// fpu_issue_sched
// Purpose: single-outstanding-operation sequencer between decode and the FPU
// execution units. It accepts one decoded fpu_op at a time, issues a
// one-cycle start pulse and then waits for completion. Fixed-latency classes
// finish after a per-class cycle count. The div/sqrt class finishes on the
// unit's done strobe. The captured result is returned over a valid/ready
// response channel.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   req_valid/ready, req_op, req_rd_idx, req_fpu_rd
//                  decode request channel
//   flush          abandon any in-flight op
//   start, start_op
//                  one-cycle issue pulse and its op code
//   unit_done      div/sqrt completion strobe
//   unit_result    FPU result bus
//   resp_valid/ready, resp_data, resp_rd_idx, resp_fpu_rd
//                  writeback response channel
//   illegal        one-cycle pulse for an unsupported op
//   busy           scheduler is not idle
module fpu_issue_sched #(
    parameter int ADD_LAT  = 3,
    parameter int MUL_LAT  = 4,
    parameter int MISC_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [4:0]  req_rd_idx,
    input  logic        req_fpu_rd,
    input  logic        flush,
    output logic        start,
    output logic [4:0]  start_op,
    input  logic        unit_done,
    input  logic [63:0] unit_result,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic [4:0]  resp_rd_idx,
    output logic        resp_fpu_rd,
    output logic        illegal,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, ISSUE, COUNT, WAIT, RESP} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] lat_q;
    logic       var_q;

    // Latency for the fixed-latency classes; 0 marks var-class or illegal ops.
    function automatic logic [3:0] fixed_lat(input logic [4:0] op);
        case (op)
            5'b00000, 5'b00001, 5'b01001, 5'b01010: fixed_lat = 4'(ADD_LAT);
            5'b00010, 5'b01011:                     fixed_lat = 4'(MUL_LAT);
            5'b00101, 5'b00110, 5'b00111, 5'b01000: fixed_lat = 4'(MISC_LAT);
            default:                                fixed_lat = 4'd0;
        endcase
    endfunction

    function automatic logic is_var_op(input logic [4:0] op);
        is_var_op = (op == 5'b00011) || (op == 5'b00100) ||
                    (op == 5'b01100) || (op == 5'b01101);
    endfunction

    // Reset also blocks acceptance, so every output reads 0 while rst is held.
    assign req_ready = (state == IDLE) && !flush && !rst;

    // Sequencer FSM. start, start_op and illegal are single-cycle pulses by
    // default. flush takes priority over every state transition. An illegal op
    // leaves the FSM in IDLE, so a new op can be accepted in the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            lat_q       <= 4'd0;
            var_q       <= 1'b0;
            start       <= 1'b0;
            start_op    <= 5'd0;
            resp_valid  <= 1'b0;
            resp_data   <= 64'd0;
            resp_rd_idx <= 5'd0;
            resp_fpu_rd <= 1'b0;
            illegal     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            start    <= 1'b0;
            start_op <= 5'd0;
            illegal  <= 1'b0;
            if (flush) begin
                state      <= IDLE;
                cnt        <= 4'd0;
                resp_valid <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid && req_ready) begin
                            if (req_op >= 5'b01110) begin
                                illegal <= 1'b1;
                            end else begin
                                state       <= ISSUE;
                                busy        <= 1'b1;
                                start       <= 1'b1;
                                start_op    <= req_op;
                                resp_rd_idx <= req_rd_idx;
                                resp_fpu_rd <= req_fpu_rd;
                                var_q       <= is_var_op(req_op);
                                lat_q       <= fixed_lat(req_op);
                            end
                        end
                    end
                    ISSUE: begin
                        if (var_q) begin
                            state <= WAIT;
                        end else begin
                            state <= COUNT;
                            cnt   <= lat_q;
                        end
                    end
                    COUNT: begin
                        if (cnt == 4'd1) begin
                            resp_data  <= unit_result;
                            resp_valid <= 1'b1;
                            cnt        <= 4'd0;
                            state      <= RESP;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    WAIT: begin
                        if (unit_done) begin
                            resp_data  <= unit_result;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end
                    end
                    RESP: begin
                        if (resp_ready) begin
                            resp_valid <= 1'b0;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fpu_issue_sched.sv
// tb_fpu_issue_sched
// Purpose: self-checking bench for fpu_issue_sched. Each request is modelled
// as one transaction with an expected cycle timeline. The timeline gives the
// start cycle, the capture cycle, the span of resp_valid and the busy span.
// The timeline is derived from the op class and the chosen latency,
// back-pressure and flush points. Cycle 0 is the accept cycle.
module tb_fpu_issue_sched;

    localparam int ADD_LAT  = 3;
    localparam int MUL_LAT  = 4;
    localparam int MISC_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [4:0]  req_rd_idx;
    logic        req_fpu_rd;
    logic        flush;
    logic        start;
    logic [4:0]  start_op;
    logic        unit_done;
    logic [63:0] unit_result;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic [4:0]  resp_rd_idx;
    logic        resp_fpu_rd;
    logic        illegal;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    fpu_issue_sched #(
        .ADD_LAT  (ADD_LAT),
        .MUL_LAT  (MUL_LAT),
        .MISC_LAT (MISC_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_rd_idx  (req_rd_idx),
        .req_fpu_rd  (req_fpu_rd),
        .flush       (flush),
        .start       (start),
        .start_op    (start_op),
        .unit_done   (unit_done),
        .unit_result (unit_result),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_rd_idx (resp_rd_idx),
        .resp_fpu_rd (resp_fpu_rd),
        .illegal     (illegal),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid   = 1'b0;
        req_op      = 5'd0;
        req_rd_idx  = 5'd0;
        req_fpu_rd  = 1'b0;
        flush       = 1'b0;
        unit_done   = 1'b0;
        unit_result = 64'd0;
        resp_ready  = 1'b0;
    endtask

    // Runs one request from the accept cycle to a few cycles past its end.
    // done_at is the cycle at which unit_done pulses. It is the completion
    // point for the var class and a stray strobe for every other class.
    // rdy_delay is the number of cycles resp_ready stays low after resp_valid
    // rises. flush_at is the cycle that carries flush, or 0 for no flush.
    task automatic run_op(input logic [4:0] op, input logic [4:0] rd, input logic fr,
                          input int done_at, input int rdy_delay, input int flush_at);
        logic [63:0] res [0:127];
        int  lat;
        int  cap;
        int  hs;
        int  last;
        int  lim;
        bit  legal;
        bit  isvar;
        bit  e_busy;
        bit  e_rv;
        bit  e_start;
        bit  e_ill;
        lat   = 0;
        isvar = 0;
        legal = 1;
        if (op inside {5'd0, 5'd1, 5'd9, 5'd10})        lat = ADD_LAT;
        else if (op inside {5'd2, 5'd11})               lat = MUL_LAT;
        else if (op inside {[5'd5:5'd8]})               lat = MISC_LAT;
        else if (op inside {5'd3, 5'd4, 5'd12, 5'd13})  isvar = 1;
        else                                            legal = 0;
        cap  = isvar ? done_at : 1 + lat;
        hs   = cap + 1 + rdy_delay;
        last = (flush_at > 0 && flush_at < hs) ? flush_at : hs;
        lim  = (done_at > last) ? done_at + 1 : last + 3;

        req_valid  = 1'b1;
        req_op     = op;
        req_rd_idx = rd;
        req_fpu_rd = fr;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL accept_ready op=%b: got %b expected 1", op, req_ready);
        end
        next_cycle();
        req_valid = 1'b0;
        req_op    = 5'($urandom);

        for (int k = 1; k <= lim; k++) begin
            res[k]      = {$urandom, $urandom};
            unit_result = res[k];
            unit_done   = (k == done_at);
            resp_ready  = (k >= cap + 1 + rdy_delay);
            flush       = (k == flush_at);
            @(negedge clk);
            e_start = legal && (k == 1);
            e_ill   = !legal && (k == 1);
            e_busy  = legal && (k <= last);
            e_rv    = legal && (k > cap) && (k <= last);
            tests_run++;
            if (start !== e_start || start_op !== (e_start ? op : 5'd0)) begin
                tests_failed++;
                $display("[TB] FAIL start op=%b k=%0d: got %b/%b expected %b/%b",
                         op, k, start, start_op, e_start, (e_start ? op : 5'd0));
            end
            tests_run++;
            if (illegal !== e_ill || busy !== e_busy) begin
                tests_failed++;
                $display("[TB] FAIL illegal_busy op=%b k=%0d: got %b/%b expected %b/%b",
                         op, k, illegal, busy, e_ill, e_busy);
            end
            tests_run++;
            if (resp_valid !== e_rv || req_ready !== (!e_busy && !flush)) begin
                tests_failed++;
                $display("[TB] FAIL valid_ready op=%b k=%0d: got %b/%b expected %b/%b",
                         op, k, resp_valid, req_ready, e_rv, (!e_busy && !flush));
            end
            if (e_rv) begin
                tests_run++;
                if (resp_data !== res[cap] || resp_rd_idx !== rd || resp_fpu_rd !== fr) begin
                    tests_failed++;
                    $display("[TB] FAIL resp_payload op=%b k=%0d: got %h/%0d/%b expected %h/%0d/%b",
                             op, k, resp_data, resp_rd_idx, resp_fpu_rd, res[cap], rd, fr);
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    // Reset values while rst is held, then readiness once it is released.
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        @(negedge clk);
        tests_run++;
        if ({req_ready, start, start_op, resp_valid, resp_data, resp_rd_idx,
             resp_fpu_rd, illegal, busy} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got ready=%b start=%b valid=%b busy=%b expected all 0",
                     req_ready, start, resp_valid, busy);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_release: got ready=%b busy=%b expected 1/0", req_ready, busy);
        end
        next_cycle();
    endtask

    task automatic test_add_timing();
        run_op(5'b00000, 5'd7, 1'b1, 0, 0, 0);
    endtask

    task automatic test_back_pressure();
        run_op(5'b01011, 5'd12, 1'b0, 0, 6, 0);
    endtask

    // Div completes on its strobe; a misc op ignores a stray strobe.
    task automatic test_var_latency();
        run_op(5'b00011, 5'd21, 1'b1, 20, 1, 0);
        run_op(5'b00110, 5'd4, 1'b1, 4, 0, 0);
    endtask

    // Illegal op followed by a misc op accepted in the very next cycle.
    task automatic test_illegal();
        logic [63:0] r;
        r          = {$urandom, $urandom};
        req_valid  = 1'b1;
        req_op     = 5'b11111;
        req_rd_idx = 5'd9;
        next_cycle();
        req_op     = 5'b00101;
        req_rd_idx = 5'd3;
        req_fpu_rd = 1'b0;
        @(negedge clk);
        tests_run++;
        if (illegal !== 1'b1 || start !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL illegal_pulse: got ill=%b start=%b ready=%b busy=%b expected 1/0/1/0",
                     illegal, start, req_ready, busy);
        end
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (illegal !== 1'b0 || start !== 1'b1 || start_op !== 5'b00101) begin
            tests_failed++;
            $display("[TB] FAIL illegal_then_misc: got ill=%b start=%b op=%b expected 0/1/00101",
                     illegal, start, start_op);
        end
        next_cycle();
        unit_result = r;
        next_cycle();
        unit_result = ~r;
        resp_ready  = 1'b1;
        @(negedge clk);
        tests_run++;
        if (resp_valid !== 1'b1 || resp_data !== r || resp_rd_idx !== 5'd3) begin
            tests_failed++;
            $display("[TB] FAIL misc_resp: got %b/%h/%0d expected 1/%h/3",
                     resp_valid, resp_data, resp_rd_idx, r);
        end
        next_cycle();
        @(negedge clk);
        tests_run++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL misc_done: got valid=%b busy=%b ready=%b expected 0/0/1",
                     resp_valid, busy, req_ready);
        end
        next_cycle();
        idle_inputs();
    endtask

    // fsqrt flushed while waiting; the later done strobe must be ignored.
    task automatic test_flush();
        run_op(5'b01101, 5'd30, 1'b1, 8, 0, 5);
        run_op(5'b00001, 5'd2, 1'b0, 0, 3, 6);
    endtask

    // rst asserted mid-COUNT clears everything; a following op still works.
    task automatic test_reset_mid();
        req_valid  = 1'b1;
        req_op     = 5'b00010;
        req_rd_idx = 5'd17;
        req_fpu_rd = 1'b1;
        next_cycle();
        idle_inputs();
        resp_ready = 1'b1;
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_busy: got %b expected 1", busy);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({start, start_op, resp_valid, resp_data, resp_rd_idx, resp_fpu_rd,
             illegal, busy} !== '0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_clear: got valid=%b busy=%b rd=%0d ready=%b expected 0/0/0/1",
                     resp_valid, busy, resp_rd_idx, req_ready);
        end
        for (int k = 0; k < 8; k++) begin
            unit_done = 1'b1;
            next_cycle();
            @(negedge clk);
            tests_run++;
            if (resp_valid !== 1'b0 || start !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_mid_quiet k=%0d: got valid=%b start=%b busy=%b expected 0",
                         k, resp_valid, start, busy);
            end
        end
        next_cycle();
        idle_inputs();
        run_op(5'b01010, 5'd5, 1'b1, 3, 1, 0);
    endtask

    // Random ops, strobe points, back-pressure and occasional flushes.
    task automatic test_random();
        int dn;
        int fl;
        for (int i = 0; i < 40; i++) begin
            dn = int'($urandom_range(2, 12));
            fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0;
            run_op(5'($urandom), 5'($urandom), 1'($urandom), dn,
                   int'($urandom_range(0, 4)), fl);
        end
    endtask

    initial begin
        test_reset();
        test_add_timing();
        test_back_pressure();
        test_var_latency();
        test_illegal();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
